// File: rtl/matmul_seq_ctrl_if.sv
// Host <-> sequencer bundle: instruction byte in, MMU/memory control and status out.
interface matmul_seq_ctrl_if #(
    parameter int unsigned N         = 2,
    parameter int unsigned EXTRA_LAT = 0
);
    localparam int unsigned IDX_W = $clog2(N * N);
    localparam int unsigned C     = 3 * N + EXTRA_LAT;
    localparam int unsigned CYC_W = $clog2(C);

    logic [7:0]       instrn;
    logic             mem_load_mat;
    logic [IDX_W:0]   mem_addr;
    logic             mmu_clear;
    logic             mmu_en;
    logic [CYC_W-1:0] mmu_cycle;
    logic [IDX_W-1:0] output_select;
    logic             out_valid;
    logic             busy;
    logic             load_err;

    // Host side
    modport master (
        output instrn,
        input  mem_load_mat, mem_addr, mmu_clear, mmu_en, mmu_cycle,
        input  output_select, out_valid, busy, load_err
    );

    // Sequencer side
    modport slave (
        input  instrn,
        output mem_load_mat, mem_addr, mmu_clear, mmu_en, mmu_cycle,
        output output_select, out_valid, busy, load_err
    );
endinterface

// File: rtl/matmul_seq_ctrl.sv
// Sequencer for an NxN systolic matmul: tracks operand loads, runs clear/compute, exposes results.
module matmul_seq_ctrl #(
    parameter int unsigned N         = 2,
    parameter int unsigned EXTRA_LAT = 0
) (
    input logic                clk,
    input logic                rst,
    matmul_seq_ctrl_if.slave   io_bus
);
    localparam int unsigned IDX_W = $clog2(N * N);
    localparam int unsigned C     = 3 * N + EXTRA_LAT;
    localparam int unsigned CYC_W = $clog2(C);
    localparam int unsigned NN    = N * N;
    localparam int unsigned MW    = 2 * NN;

    typedef enum logic [2:0] {StIdle, StLoad, StClear, StCompute, StDone} state_e;

    state_e           r_state, w_state_d;
    logic [MW-1:0]    r_mask, w_mask_d, w_onehot;
    logic             w_load_en, w_sel, w_out_en, w_abort;
    logic [3:0]       w_idx;
    logic [5:0]       w_bit;
    logic             w_idx_ok, w_accept, w_legal, w_reject, w_full;

    logic             r_mem_load_mat, w_mem_load_mat_d;
    logic [IDX_W:0]   r_mem_addr, w_mem_addr_d;
    logic             r_mmu_clear, w_mmu_clear_d;
    logic             r_mmu_en, w_mmu_en_d;
    logic [CYC_W-1:0] r_mmu_cycle, w_mmu_cycle_d;
    logic [IDX_W-1:0] r_output_select, w_output_select_d;
    logic             r_out_valid, w_out_valid_d;
    logic             r_busy, w_busy_d;
    logic             r_load_err, w_load_err_d;

    assign w_load_en = io_bus.instrn[0];
    assign w_sel     = io_bus.instrn[1];
    assign w_out_en  = io_bus.instrn[2];
    assign w_abort   = io_bus.instrn[3];
    assign w_idx     = io_bus.instrn[7:4];

    // Range check uses the full nibble so out-of-range indices never alias onto real elements.
    assign w_idx_ok = ({1'b0, w_idx} < 5'(NN));
    assign w_accept = (r_state == StIdle) || (r_state == StLoad) || (r_state == StDone);
    assign w_legal  = w_load_en && !w_abort && w_idx_ok && w_accept;
    assign w_reject = w_load_en && !w_abort && !w_legal;

    // Mask is packed densely: A elements in [NN-1:0], B elements above.
    assign w_bit    = (w_sel ? 6'(NN) : 6'd0) + 6'(w_idx);
    assign w_onehot = MW'(1) << w_bit;
    assign w_full   = ((r_mask | w_onehot) == {MW{1'b1}});

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state logic; abort overrides everything
    always_comb begin
        w_state_d = r_state;
        if (w_abort) begin
            w_state_d = StIdle;
        end else begin
            unique case (r_state)
                StIdle:    if (w_legal) w_state_d = StLoad;
                StLoad:    if (w_legal && w_full) w_state_d = StClear;
                StClear:   w_state_d = StCompute;
                StCompute: if (r_mmu_cycle == CYC_W'(C - 1)) w_state_d = StDone;
                StDone:    if (w_legal) w_state_d = StLoad;
                default:   w_state_d = StIdle;
            endcase
        end
    end

    // Next values of the registered outputs and the load mask
    always_comb begin
        w_mask_d = r_mask;
        if (w_abort) begin
            w_mask_d = '0;
        end else if (w_legal) begin
            w_mask_d = w_full ? '0 : (r_mask | w_onehot);
        end

        w_mem_load_mat_d = w_legal;
        w_mem_addr_d     = w_legal ? {w_sel, w_idx[IDX_W-1:0]} : '0;
        w_mmu_clear_d    = (w_state_d == StClear);
        w_mmu_en_d       = (w_state_d == StCompute);
        w_mmu_cycle_d    = ((r_state == StCompute) && (w_state_d == StCompute)) ?
                           r_mmu_cycle + CYC_W'(1) : '0;
        w_out_valid_d    = (w_state_d == StDone);
        w_busy_d         = w_mmu_clear_d || w_mmu_en_d;
        w_load_err_d     = w_reject;

        // load_en outranks out_en, so a select only happens on a pure read request
        w_output_select_d = r_output_select;
        if (w_abort) begin
            w_output_select_d = '0;
        end else if ((r_state == StDone) && !w_load_en && w_out_en && w_idx_ok) begin
            w_output_select_d = w_idx[IDX_W-1:0];
        end
    end

    // Output and mask registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mask          <= '0;
            r_mem_load_mat  <= 1'b0;
            r_mem_addr      <= '0;
            r_mmu_clear     <= 1'b0;
            r_mmu_en        <= 1'b0;
            r_mmu_cycle     <= '0;
            r_output_select <= '0;
            r_out_valid     <= 1'b0;
            r_busy          <= 1'b0;
            r_load_err      <= 1'b0;
        end else begin
            r_mask          <= w_mask_d;
            r_mem_load_mat  <= w_mem_load_mat_d;
            r_mem_addr      <= w_mem_addr_d;
            r_mmu_clear     <= w_mmu_clear_d;
            r_mmu_en        <= w_mmu_en_d;
            r_mmu_cycle     <= w_mmu_cycle_d;
            r_output_select <= w_output_select_d;
            r_out_valid     <= w_out_valid_d;
            r_busy          <= w_busy_d;
            r_load_err      <= w_load_err_d;
        end
    end

    assign io_bus.mem_load_mat  = r_mem_load_mat;
    assign io_bus.mem_addr      = r_mem_addr;
    assign io_bus.mmu_clear     = r_mmu_clear;
    assign io_bus.mmu_en        = r_mmu_en;
    assign io_bus.mmu_cycle     = r_mmu_cycle;
    assign io_bus.output_select = r_output_select;
    assign io_bus.out_valid     = r_out_valid;
    assign io_bus.busy          = r_busy;
    assign io_bus.load_err      = r_load_err;
endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Self-checking bench: N=2 and N=3/EXTRA_LAT=2 sequencers against a behavioural model.
module tb_matmul_seq_ctrl;
    localparam int PH_IDLE = 0, PH_LOAD = 1, PH_CLEAR = 2, PH_COMP = 3, PH_DONE = 4;
    localparam logic [7:0] ABORT = 8'h08;

    typedef struct {
        int      ph;
        bit [31:0] loaded;
        int      cyc;
        int      mem_load, mem_addr, clr, en, mcyc, osel, ov, busy, lerr;
    } mdl_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matmul_seq_ctrl_if #(.N(2), .EXTRA_LAT(0)) bus2 ();
    matmul_seq_ctrl_if #(.N(3), .EXTRA_LAT(2)) bus3 ();

    matmul_seq_ctrl #(.N(2), .EXTRA_LAT(0)) u_dut2 (.clk(clk), .rst(rst), .io_bus(bus2));
    matmul_seq_ctrl #(.N(3), .EXTRA_LAT(2)) u_dut3 (.clk(clk), .rst(rst), .io_bus(bus3));

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    mdl_t m2, m3;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.ph = PH_IDLE; r.loaded = '0; r.cyc = 0;
        r.mem_load = 0; r.mem_addr = 0; r.clr = 0; r.en = 0; r.mcyc = 0;
        r.osel = 0; r.ov = 0; r.busy = 0; r.lerr = 0;
        return r;
    endfunction

    // One clock of the job protocol: n = dimension, c = compute cycles, iw = index width
    function automatic mdl_t mdl_step(input mdl_t m, input int n, input int c, input int iw,
                                      input logic [7:0] ins);
        mdl_t r;
        int   nn, idx, sel;
        nn  = n * n;
        idx = int'(ins[7:4]);
        sel = int'(ins[1]);
        if (ins[3]) begin
            r = mdl_reset();
        end else begin
            r = m;
            r.mem_load = 0; r.mem_addr = 0; r.lerr = 0;
            if (m.ph == PH_CLEAR) begin
                r.ph = PH_COMP; r.cyc = 0;
            end else if (m.ph == PH_COMP) begin
                if (m.cyc == c - 1) r.ph = PH_DONE;
                else r.cyc = m.cyc + 1;
            end
            if (ins[0]) begin
                if ((m.ph == PH_IDLE || m.ph == PH_LOAD || m.ph == PH_DONE) && idx < nn) begin
                    r.mem_load = 1;
                    r.mem_addr = (sel << iw) + idx;
                    r.loaded[sel * nn + idx] = 1'b1;
                    if ($countones(r.loaded) == 2 * nn) begin
                        r.ph = PH_CLEAR; r.loaded = '0;
                    end else begin
                        r.ph = PH_LOAD;
                    end
                end else begin
                    r.lerr = 1;
                end
            end else if (ins[2] && m.ph == PH_DONE && idx < nn) begin
                r.osel = idx;
            end
        end
        r.clr  = (r.ph == PH_CLEAR) ? 1 : 0;
        r.en   = (r.ph == PH_COMP) ? 1 : 0;
        r.mcyc = r.en ? r.cyc : 0;
        r.ov   = (r.ph == PH_DONE) ? 1 : 0;
        r.busy = (r.clr != 0 || r.en != 0) ? 1 : 0;
        return r;
    endfunction

    // Model advances on the same edges as the DUTs
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m2 <= mdl_reset();
            m3 <= mdl_reset();
        end else begin
            m2 <= mdl_step(m2, 2, 6, 2, bus2.instrn);
            m3 <= mdl_step(m3, 3, 11, 4, bus3.instrn);
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("d2 mem_load_mat", int'(bus2.mem_load_mat), m2.mem_load);
            chk("d2 mem_addr", int'(bus2.mem_addr), m2.mem_addr);
            chk("d2 mmu_clear", int'(bus2.mmu_clear), m2.clr);
            chk("d2 mmu_en", int'(bus2.mmu_en), m2.en);
            chk("d2 mmu_cycle", int'(bus2.mmu_cycle), m2.mcyc);
            chk("d2 output_select", int'(bus2.output_select), m2.osel);
            chk("d2 out_valid", int'(bus2.out_valid), m2.ov);
            chk("d2 busy", int'(bus2.busy), m2.busy);
            chk("d2 load_err", int'(bus2.load_err), m2.lerr);
            chk("d3 mem_load_mat", int'(bus3.mem_load_mat), m3.mem_load);
            chk("d3 mem_addr", int'(bus3.mem_addr), m3.mem_addr);
            chk("d3 mmu_clear", int'(bus3.mmu_clear), m3.clr);
            chk("d3 mmu_en", int'(bus3.mmu_en), m3.en);
            chk("d3 mmu_cycle", int'(bus3.mmu_cycle), m3.mcyc);
            chk("d3 output_select", int'(bus3.output_select), m3.osel);
            chk("d3 out_valid", int'(bus3.out_valid), m3.ov);
            chk("d3 busy", int'(bus3.busy), m3.busy);
            chk("d3 load_err", int'(bus3.load_err), m3.lerr);
        end
    end

    function automatic logic [7:0] ld(input int sel, input int idx);
        return {4'(idx), 2'b00, 1'(sel), 1'b1};
    endfunction

    function automatic logic [7:0] oe(input int idx);
        return {4'(idx), 4'b0100};
    endfunction

    task automatic tick(input logic [7:0] i2, input logic [7:0] i3);
        bus2.instrn = i2;
        bus3.instrn = i3;
        @(posedge clk);
        #2;
        bus2.instrn = 8'h00;
        bus3.instrn = 8'h00;
    endtask

    // Element k of the N=2 job: A0..A3 then B0..B3
    task automatic load2(input int k);
        tick(ld(k / 4, k % 4), 8'h00);
    endtask

    task automatic run_job(input int which, input int exp_c);
        int cnt = 0;
        bit done = 1'b0;
        for (int t = 0; t < 30 && !done; t++) begin
            tick(8'h00, 8'h00);
            if ((which == 2) ? bus2.mmu_en : bus3.mmu_en) begin
                chk("job mmu_cycle step", (which == 2) ? int'(bus2.mmu_cycle) : int'(bus3.mmu_cycle), cnt);
                cnt++;
            end else if ((which == 2) ? bus2.out_valid : bus3.out_valid) begin
                done = 1'b1;
            end
        end
        chk("job compute cycles", cnt, exp_c);
        chk("job reached done", int'(done), 1);
        chk("job busy in done", (which == 2) ? int'(bus2.busy) : int'(bus3.busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int strobes;
        bit hit;
        rst = 1'b1;
        bus2.instrn = 8'h00;
        bus3.instrn = 8'h00;
        #1 rst = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("reset out_valid", int'(bus2.out_valid), 0);
        chk("reset busy", int'(bus2.busy), 0);
        chk("reset mem_load_mat", int'(bus2.mem_load_mat), 0);
        @(posedge clk);
        #2 rst = 1'b1;

        // Full N=2 job: addresses 0..7, one clear, six compute steps
        for (int k = 0; k < 8; k++) begin
            load2(k);
            chk("t1 write strobe", int'(bus2.mem_load_mat), 1);
            chk("t1 write addr", int'(bus2.mem_addr), k);
        end
        chk("t1 clear pulse", int'(bus2.mmu_clear), 1);
        chk("t1 busy in clear", int'(bus2.busy), 1);
        chk("t1 no en in clear", int'(bus2.mmu_en), 0);
        run_job(2, 6);

        // Result select in DONE, then back-to-back job
        tick(oe(3), 8'h00);
        chk("t4 output_select", int'(bus2.output_select), 3);
        tick(oe(6), 8'h00);
        chk("t4 bad select ignored", int'(bus2.output_select), 3);
        tick(ld(1, 0), 8'h00);
        chk("t4 out_valid drops", int'(bus2.out_valid), 0);
        chk("t4 addr B0", int'(bus2.mem_addr), 4);
        chk("t4 strobe B0", int'(bus2.mem_load_mat), 1);
        for (int k = 0; k < 4; k++) load2(k);
        for (int k = 5; k < 8; k++) load2(k);
        chk("t4 clear after job2", int'(bus2.mmu_clear), 1);
        run_job(2, 6);
        chk("t4 select held", int'(bus2.output_select), 3);

        // Abort returns everything to zero
        tick(ABORT, 8'h00);
        chk("abort output_select", int'(bus2.output_select), 0);
        chk("abort out_valid", int'(bus2.out_valid), 0);

        // Duplicate load counted once
        strobes = 0;
        tick(ld(0, 1), 8'h00); strobes += int'(bus2.mem_load_mat);
        tick(ld(0, 1), 8'h00); strobes += int'(bus2.mem_load_mat);
        for (int k = 0; k < 7; k++) begin
            if (k != 1) begin
                load2(k);
                strobes += int'(bus2.mem_load_mat);
            end
        end
        chk("t2 no clear at 7 distinct", int'(bus2.mmu_clear), 0);
        load2(7); strobes += int'(bus2.mem_load_mat);
        chk("t2 clear at 8 distinct", int'(bus2.mmu_clear), 1);
        chk("t2 write strobes", strobes, 9);
        run_job(2, 6);

        // Load during COMPUTE is rejected, then abort
        for (int k = 0; k < 8; k++) load2(k);
        hit = 1'b0;
        for (int t = 0; t < 10 && !hit; t++) begin
            tick(8'h00, 8'h00);
            hit = bus2.mmu_en && (bus2.mmu_cycle == 3'd2);
        end
        chk("t3 reached cycle 2", int'(hit), 1);
        tick(ld(0, 0), 8'h00);
        chk("t3 load_err", int'(bus2.load_err), 1);
        chk("t3 no write", int'(bus2.mem_load_mat), 0);
        chk("t3 cycle 3", int'(bus2.mmu_cycle), 3);
        tick(ABORT, 8'h00);
        chk("t3 abort mmu_en", int'(bus2.mmu_en), 0);
        chk("t3 abort busy", int'(bus2.busy), 0);
        chk("t3 abort load_err", int'(bus2.load_err), 0);
        for (int k = 0; k < 7; k++) load2(k);
        chk("t3 mask empty after abort", int'(bus2.mmu_clear), 0);
        load2(7);
        chk("t3 clear after 8", int'(bus2.mmu_clear), 1);
        tick(ABORT, 8'h00);

        // Abort during loading discards the partial mask
        for (int k = 0; k < 5; k++) load2(k);
        tick(ABORT, 8'h00);
        for (int k = 5; k < 12; k++) load2(k % 8);
        chk("abort mask discarded", int'(bus2.mmu_clear), 0);
        load2(4);
        chk("abort refill clear", int'(bus2.mmu_clear), 1);
        tick(ABORT, 8'h00);

        // Asynchronous reset mid-stream
        for (int k = 0; k < 5; k++) load2(k);
        rst = 1'b0;
        #1;
        chk("rst async mem_load_mat", int'(bus2.mem_load_mat), 0);
        chk("rst async mem_addr", int'(bus2.mem_addr), 0);
        chk("rst async busy", int'(bus2.busy), 0);
        @(posedge clk);
        #2 rst = 1'b1;
        for (int k = 5; k < 12; k++) load2(k % 8);
        chk("rst mask discarded", int'(bus2.mmu_clear), 0);
        load2(4);
        chk("rst refill clear", int'(bus2.mmu_clear), 1);
        run_job(2, 6);

        // N=3, EXTRA_LAT=2: out-of-range index, 18 loads, 11 compute cycles
        tick(8'h00, ld(0, 9));
        chk("t5 idle load_err", int'(bus3.load_err), 1);
        chk("t5 idle no write", int'(bus3.mem_load_mat), 0);
        for (int k = 0; k < 17; k++) tick(8'h00, ld(k / 9, k % 9));
        tick(8'h00, ld(0, 9));
        chk("t5 load_err idx9", int'(bus3.load_err), 1);
        chk("t5 no clear on reject", int'(bus3.mmu_clear), 0);
        tick(8'h00, ld(1, 8));
        chk("t5 clear after 18", int'(bus3.mmu_clear), 1);
        chk("t5 addr B8", int'(bus3.mem_addr), 24);
        run_job(3, 11);

        tick(8'h00, 8'h00);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
